mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the word-addressed data memory port.
- It turns byte, halfword and word CPU requests into word reads and writes on the memory.
- Sub-word stores are performed as read-modify-write.
- It sits between the datapath's memory stage and the data memory, and stalls the CPU through a ready/done handshake.

Parameters:
- ADDR_W, 16, byte-address width on both the CPU side and the memory side.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; the unit is in reset while reset=0
- req  input  1  CPU access request; sampled only when ready=1
- we  input  1  1 = store, 0 = load
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  input  ADDR_W  byte address
- wdata  input  32  store data, right-justified
- ready  output  1  unit is idle and can accept a request
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = misaligned or illegal access
- rdata  output  32  load result, valid while done=1
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  word-aligned memory address, low 2 bits always 00
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, RD, WR, RESP, ERR. All outputs decode from registered state and latched fields.
- Reset (reset=0, asynchronous): state=IDLE, all latches cleared.
  - Outputs during reset: ready=1, done=0, err=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access abandons the access immediately. mem_we drops in the same instant, no partial write occurs, and no done is produced.
- IDLE:
  - ready=1, mem_we=0.
  - req=1 at a clock edge latches we, size, sign_ext, addr and wdata.
  - Misaligned or illegal requests go to ERR: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11.
  - Word store goes to WR. All other accepted requests go to RD.
  - req=0 stays in IDLE.
- RD:
  - mem_addr = {addr[ADDR_W-1:2], 00}, mem_we=0.
  - mem_rdata is captured into word_q at the edge.
  - Next state: RESP for a load, WR for a store.
- WR:
  - mem_we=1 for exactly one cycle, mem_addr as in RD.
  - Word store: mem_wdata = wdata.
  - Byte store: word_q with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: word_q with lane addr[1] replaced by wdata[15:0].
  - Lane 0 = bits [7:0] and lane 3 = bits [31:24], i.e. little-endian.
  - Next state: RESP.
- RESP:
  - done=1, err=0. Next state: IDLE.
  - Load: rdata = selected byte or halfword from word_q, extended per sign_ext, or the whole word for size=10.
  - Store: rdata = 0.
- ERR: done=1, err=1, rdata=0, mem_we never asserted. Next state: IDLE.
- ready=0 in every state except IDLE. req while ready=0 is ignored and not queued.
- A request in the same cycle as a done pulse is not accepted; acceptance happens the following IDLE cycle at the earliest.
- Latency, counted from the acceptance edge to the edge at which done=1 is sampled:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput: one access is in flight at a time.
- Outside RD and WR: mem_addr and mem_wdata hold their last values, and mem_we=0.
- Addresses are not range-checked. The memory's own address wrap applies.

Test Plan:
- Reset: hold reset=0 for 3 cycles, with req=1 stimulus applied -> mem_we=0, ready=1, done=0, rdata=0 throughout.
- Byte load sign/zero:
  - Preload word 0x000 = 0x80FF7F01.
  - Load byte at addr 0x0002 with sign_ext=1 -> rdata=0xFFFFFFFF.
  - Load byte at addr 0x0003 with sign_ext=1 -> rdata=0xFFFFFF80.
  - Load byte at addr 0x0003 with sign_ext=0 -> rdata=0x00000080.
  - done=1 exactly 2 cycles after acceptance in each case.
- Sub-word store RMW:
  - Preload word 0x004 = 0x11223344.
  - Store byte 0xAB to addr 0x0005 -> memory word becomes 0x1122AB44.
  - Then store halfword 0xBEEF to addr 0x0006 -> memory word becomes 0xBEEFAB44.
  - mem_we high exactly one cycle per store; done 3 cycles after acceptance.
- Word store then load:
  - Store 0xDEADBEEF to addr 0x0010 -> mem_we=1 in cycle 1, done at cycle 2.
  - Load word from 0x0010 -> rdata=0xDEADBEEF.
- Errors: halfword at addr 0x0001, word at addr 0x0006, and size=11 -> done=1 and err=1 one cycle after acceptance, mem_we never 1, memory unchanged.
- Reset mid-store: assert reset=0 while in WR -> mem_we falls without waiting for a clock edge, no done pulse, and the next access after release works normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Load/store unit that turns CPU byte/halfword/word requests into word memory accesses (sub-word stores via read-modify-write).
// Latency: load 2, word store 2, sub-word store 3, error 1 cycle; one access in flight, ready=0 while busy.
module mem_access_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic              sext_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic accept;
    logic bad;
    logic word_store;

    // Little-endian lane insert of store data into the word read back from memory.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic [31:0] data);
        logic [31:0] res;
        res = word;
        case (sz)
            2'b00:   res[{lane, 3'b000} +: 8]     = data[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

    assign accept     = (state_q == IDLE) && req;
    assign bad        = (size == 2'b11) ||
                        (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00);
    assign word_store = we && (size == 2'b10);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad)             state_d = ERR;
                    else if (word_store) state_d = WR;
                    else                 state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            word_q      <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= we;
                sext_q  <= sign_ext;
                size_q  <= size;
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                // Error requests never touch the memory port, so its last values are kept.
                if (!bad) begin
                    mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                    if (word_store)
                        mem_wdata_q <= wdata;
                end
            end
            if (state_q == RD) begin
                word_q <= mem_rdata;
                if (we_q)
                    mem_wdata_q <= merge(mem_rdata, size_q, lane_q, wdata_q);
            end
        end
    end

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] load_val;

    always_comb begin
        sel_b    = word_q[{lane_q, 3'b000} +: 8];
        sel_h    = word_q[{lane_q[1], 4'b0000} +: 16];
        load_val = word_q;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & sel_b[7]}}, sel_b};
            2'b01:   load_val = {{16{sext_q & sel_h[15]}}, sel_h};
            default: load_val = word_q;
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == RESP) || (state_q == ERR);
    assign err       = (state_q == ERR);
    assign rdata     = (state_q == RESP && !we_q) ? load_val : 32'h0;
    assign mem_we    = (state_q == WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Randomized bench for mem_access_unit against a word-array memory and a byte-lane reference model.
module tb_mem_access_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'h0;
    logic              ready, done, err, mem_we;
    logic [31:0]       rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // 256-byte memory; upper address bits wrap.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pre_en)      mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Invariants that hold on every cycle.
    always @(negedge clk) begin
        check32("mem_addr_lsb", 32'(mem_addr[1:0]), 32'h0);
        check32("we_while_ready", 32'(mem_we & ready), 32'h0);
        check32("err_without_done", 32'(err & ~done), 32'h0);
    end

    function automatic bit is_bad(input logic [1:0] s, input logic [15:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] s,
                                               input logic sx, input logic [15:0] a);
        logic [31:0] v;
        int sh;
        if (s == 2'b10) return word;
        if (s == 2'b00) begin
            sh = int'(a[1:0]) * 8;
            v = (word >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            sh = int'(a[1]) * 16;
            v = (word >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] s,
                                                input logic [15:0] a, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (s == 2'b10) return d;
        if (s == 2'b00) begin
            sh = int'(a[1:0]) * 8;
            m = 32'hFF << sh;
        end else begin
            sh = int'(a[1]) * 16;
            m = 32'hFFFF << sh;
        end
        return (word & ~m) | ((d << sh) & m);
    endfunction

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = i[5:0];
        pre_val = v;
        ref_mem[i] = v;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // One CPU access; with noise, req stays high with junk fields while the unit is busy.
    task automatic access(input logic w, input logic [1:0] s, input logic sx, input logic [15:0] a,
                          input logic [31:0] d, input bit noise, output logic [31:0] got);
        bit          bad;
        int          idx, lat_exp, n, wecnt;
        logic [31:0] exp_rd;
        bad     = is_bad(s, a);
        idx     = int'(a[7:2]);
        lat_exp = bad ? 1 : (w && s != 2'b10) ? 3 : 2;
        exp_rd  = (bad || w) ? 32'h0 : model_load(ref_mem[idx], s, sx, a);
        @(negedge clk);
        check32("ready_idle", 32'(ready), 32'h1);
        req = 1'b1; we = w; size = s; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (noise) begin
            we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
            addr = 16'($urandom); wdata = $urandom;
        end else begin
            req = 1'b0;
        end
        n = 0; wecnt = 0; got = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wecnt++;
                check32("mem_addr", 32'(mem_addr), 32'({a[15:2], 2'b00}));
            end
            if (done) begin
                n = i;
                got = rdata;
                check32("err", 32'(err), 32'(bad));
                break;
            end
            check32("ready_busy", 32'(ready), 32'h0);
        end
        req = 1'b0;
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=none expected=latency %0d", lat_exp);
        end else begin
            check32("latency", n, lat_exp);
            check32("rdata", got, exp_rd);
        end
        check32("mem_we_count", wecnt, (w && !bad) ? 1 : 0);
        if (w && !bad) ref_mem[idx] = model_store(ref_mem[idx], s, a, d);
        check32("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] got;
        logic        w, sx;
        logic [1:0]  s;
        logic [15:0] a;

        // Reset held with an active request: unit must stay idle and quiet.
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 16'h0010; wdata = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            check32("rst_ready", 32'(ready), 32'h1);
            check32("rst_done", 32'(done), 32'h0);
            check32("rst_err", 32'(err), 32'h0);
            check32("rst_rdata", rdata, 32'h0);
            check32("rst_mem_we", 32'(mem_we), 32'h0);
            check32("rst_mem_addr", 32'(mem_addr), 32'h0);
            check32("rst_mem_wdata", mem_wdata, 32'h0);
        end
        req = 1'b0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        @(negedge clk);
        reset = 1'b1;

        // Byte loads, sign and zero extension.
        preload(0, 32'h80FF7F01);
        access(1'b0, 2'b00, 1'b1, 16'h0002, 32'h0, 1'b0, got);
        check32("lit_lb2_sx", got, 32'hFFFFFFFF);
        access(1'b0, 2'b00, 1'b1, 16'h0003, 32'h0, 1'b1, got);
        check32("lit_lb3_sx", got, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b0, 16'h0003, 32'h0, 1'b0, got);
        check32("lit_lb3_zx", got, 32'h00000080);

        // Sub-word read-modify-write stores.
        preload(1, 32'h11223344);
        access(1'b1, 2'b00, 1'b0, 16'h0005, 32'h000000AB, 1'b0, got);
        check32("lit_sb", mem[1], 32'h1122AB44);
        access(1'b1, 2'b01, 1'b0, 16'h0006, 32'h0000BEEF, 1'b1, got);
        check32("lit_sh", mem[1], 32'hBEEFAB44);

        // Word store then load back.
        access(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, got);
        access(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 1'b0, got);
        check32("lit_lw", got, 32'hDEADBEEF);

        // Misaligned and illegal accesses.
        access(1'b1, 2'b01, 1'b0, 16'h0001, 32'h12345678, 1'b0, got);
        access(1'b1, 2'b10, 1'b0, 16'h0006, 32'h12345678, 1'b1, got);
        access(1'b1, 2'b11, 1'b0, 16'h0004, 32'h12345678, 1'b0, got);
        check32("lit_err_mem", mem[1], 32'hBEEFAB44);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            w  = 1'($urandom);
            sx = 1'($urandom);
            s  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'b10) a[1:0] = 2'b00;
                if (s == 2'b01) a[0] = 1'b0;
            end
            access(w, s, sx, a, $urandom, bit'($urandom_range(0, 1)), got);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset while in WR: write enable drops without a clock edge, nothing written.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 16'h0020; wdata = 32'h5A5A1234;
        @(posedge clk);
        #1 req = 1'b0;
        check32("mid_wr_we", 32'(mem_we), 32'h1);
        #2 reset = 1'b0;
        #1;
        check32("mid_rst_we", 32'(mem_we), 32'h0);
        check32("mid_rst_done", 32'(done), 32'h0);
        check32("mid_rst_ready", 32'(ready), 32'h1);
        repeat (2) begin
            @(negedge clk);
            check32("mid_rst_no_done", 32'(done), 32'h0);
        end
        reset = 1'b1;
        check32("mid_rst_mem", mem[8], ref_mem[8]);
        access(1'b1, 2'b00, 1'b0, 16'h0021, 32'h000000C3, 1'b0, got);
        access(1'b0, 2'b01, 1'b1, 16'h0020, 32'h0, 1'b0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
